uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Byte-oriented UART receiver with a receive FIFO and the team's 8-bit control/status register handshake. It deserialises 8N1 frames from the RXD pin, buffers complete bytes in a first-word-fall-through FIFO, and presents them to the CPU bus side through RX_CONTROL, RX_STATUS and RX_DATA. It is the receive counterpart of the existing UART transmit path and sits beside it inside the UART peripheral wrapper.

## Interface
- CLKS_PER_BIT, 868: clock cycles per bit (100 MHz / 115200); must be at least 4.
- FIFO_AW, 8: FIFO address width; depth = 2^FIFO_AW = 256 bytes.
- CLK  in  1  system clock; all logic is clocked on the rising edge.
- RST_N  in  1  reset, synchronous and active-low.
- RXD  in  1  asynchronous serial input; idles high.
- RX_CONTROL  in  8  command register: 8'hFF = pop, 8'h80 = clear errors, any other value = no-op.
- RX_STATUS  out  8  8'hFF when the FIFO is non-empty, 8'h00 when empty.
- RX_DATA  out  8  head-of-FIFO byte; valid only while RX_STATUS == 8'hFF.
- RX_ERR  out  8  sticky flags: bit0 = framing, bit1 = overrun, bit2 = parity (configured builds only); bits 7:3 = 0.

## Operation
- RXD passes through a 2-FF synchronizer before use. Detection latency is 2 cycles.
- Receiver FSM states:
  - IDLE: wait for the synchronized RXD to go low.
  - START: after CLKS_PER_BIT/2 cycles, sample RXD. If it is still 0, go to DATA; if it is 1 (glitch), return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles at bit centre, LSB first, 8 bits. Bit counter is 3 bits.
  - PARITY: present only with the macro set; one extra sample.
  - STOP: sample at bit centre. On 1, push the byte and go to IDLE. On 0, set framing, discard the byte, go to BREAK.
  - BREAK: wait for RXD high, then go to IDLE.
- Bit-time counter: $clog2(CLKS_PER_BIT) bits wide; reloads on every state transition.
- FIFO: FWFT, with read/write pointers of FIFO_AW bits plus an occupancy count of FIFO_AW+1 bits. Pointers wrap modulo depth.
- Pop: acts on the cycle RX_CONTROL changes to 8'hFF from any other value. Holding 8'hFF pops exactly one byte. A pop while empty is ignored.
- Clear errors: acts on the change to 8'h80 and zeroes RX_ERR.
- Push while full: the new byte is dropped and overrun is set. Exception: a pop in the same cycle frees a slot, so the push is accepted and there is no overrun.
- Push and pop in the same cycle on a non-empty FIFO: count is unchanged.
- Push into an empty FIFO: RX_STATUS goes to 8'hFF on the next cycle.
- Error flags are sticky until cleared. A clear and a new error in the same cycle leave the flag set.

## Timing
- Reset values: RX_STATUS = 8'h00, RX_DATA = 8'h00, RX_ERR = 8'h00, FSM = IDLE, pointers and count = 0, synchronizer = 2'b11.
- Reset mid-frame abandons the frame. A partially received byte is never pushed.
- Stop-bit sample to RX_STATUS/RX_DATA valid: 1 cycle (registered push, FWFT output).
- Pop edge to next RX_DATA (or RX_STATUS = 8'h00): 1 cycle.
- Start-edge to stop-bit sample: 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (plus CLKS_PER_BIT with parity).
- The next frame may begin in the cycle after STOP returns to IDLE.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state checks even parity over the 8 data bits.
  - On mismatch, RX_ERR[2] is set and the byte is still pushed.
- Undefined:
  - Frame is 8N1 and the PARITY state does not exist.
  - RX_ERR[2] is constant 0.

## Structure
- Shared package uart_pkg:
  - FSM state enum.
  - Constants UART_STAT_READY = 8'hFF and UART_STAT_EMPTY = 8'h00.
  - Constants UART_CMD_POP = 8'hFF and UART_CMD_CLR = 8'h80.
  - RX_ERR bit indices.
- One sub-module, sync_fifo: parameterised on width and address width, with push/pop/full/empty/count and FWFT output. It is reused unchanged by the transmit path.

## Test plan
(Bench uses CLKS_PER_BIT = 16.)
- Reset: drive RST_N = 0 for 3 cycles mid-frame -> all outputs 0, no byte pushed.
- Single frame 8'hA5 -> RX_STATUS = 8'hFF and RX_DATA = 8'hA5. RX_CONTROL = 8'hFF held for 5 cycles -> exactly one pop, RX_STATUS = 8'h00.
- 258 back-to-back frames (i·3 mod 256) with no pops -> 256 bytes stored and RX_ERR[1] = 1. Draining yields 0, 3, 6, ... in order, wrapping correctly.
- Stop bit forced 0 on 8'h3C -> RX_ERR[0] = 1 and FIFO unchanged. RX_CONTROL = 8'h80 -> RX_ERR = 0.
- 4-cycle low glitch on idle RXD -> FSM returns to IDLE, nothing pushed.
- With UART_RX_PARITY_EN: frame 8'h01 sent with parity 0 -> RX_ERR[2] = 1 and RX_DATA = 8'h01.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, register command/status codes and RX_ERR bit positions.
// UART_RX_PARITY_EN adds the PARITY state to the receiver FSM.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   localparam logic [7:0] UART_STAT_READY = 8'hFF;
   localparam logic [7:0] UART_STAT_EMPTY = 8'h00;
   localparam logic [7:0] UART_CMD_POP    = 8'hFF;
   localparam logic [7:0] UART_CMD_CLR    = 8'h80;

   localparam int ERR_FRAME   = 0;
   localparam int ERR_OVERRUN = 1;
   localparam int ERR_PARITY  = 2;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word lives in a register so it resets cleanly
// and the storage array keeps a registered read.
module sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [W-1:0]  head_q, head_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      if (do_push && (empty_o || (do_pop && count_q == (AW+1)'(1)))) begin
         head_d = wdata_i;
      end else if (do_pop && count_q > (AW+1)'(1)) begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign rdata_o = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with a FWFT receive FIFO behind the RX_CONTROL/RX_STATUS/RX_DATA handshake.
// Define UART_RX_PARITY_EN for an even-parity bit between the data and stop bits.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       RXD,
   input  logic [7:0] RX_CONTROL,
   output logic [7:0] RX_STATUS,
   output logic [7:0] RX_DATA,
   output logic [7:0] RX_ERR
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] RELOAD_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] RELOAD_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_e        state_q, state_d;
   logic [1:0]       sync_q;
   logic             rxd_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       ctrl_q;
   logic [2:0]       err_q, err_d;
   logic             tick;
   logic             byte_push, frame_err, overrun;
   logic             pop_cmd, clr_cmd;
   logic             fifo_full, fifo_empty;
   logic [FIFO_AW:0] fifo_count;
   logic [7:0]       fifo_rdata;
`ifdef UART_RX_PARITY_EN
   logic             parity_err;
`endif

   assign rxd_s = sync_q[1];
   assign tick  = (cnt_q == '0);

   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!rxd_s) state_d = ST_START;
         ST_START: if (tick) state_d = rxd_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
         ST_DATA:   if (tick && bit_q == 3'd7) state_d = ST_PARITY;
         ST_PARITY: if (tick) state_d = ST_STOP;
`else
         ST_DATA:   if (tick && bit_q == 3'd7) state_d = ST_STOP;
`endif
         ST_STOP:  if (tick) state_d = rxd_s ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rxd_s) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      byte_push = 1'b0;
      frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err = 1'b0;
`endif
      if (state_q != ST_IDLE && state_q != ST_BREAK && !tick) cnt_d = cnt_q - CNT_W'(1);
      // The first sample lands half a bit into the start bit, every later one a full bit apart.
      if (state_d != state_q || (state_q == ST_DATA && tick)) begin
         cnt_d = (state_d == ST_START) ? RELOAD_HALF : RELOAD_FULL;
      end
      case (state_q)
         ST_START: bit_d = '0;
         ST_DATA: begin
            if (tick) begin
               shift_d = {rxd_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: if (tick && (rxd_s != even_parity(shift_q))) parity_err = 1'b1;
`endif
         ST_STOP: begin
            if (tick) begin
               byte_push = rxd_s;
               frame_err = !rxd_s;
            end
         end
         default: ;
      endcase
   end

   assign pop_cmd = (RX_CONTROL == UART_CMD_POP) && (ctrl_q != UART_CMD_POP);
   assign clr_cmd = (RX_CONTROL == UART_CMD_CLR) && (ctrl_q != UART_CMD_CLR);
   assign overrun = byte_push && fifo_full && !(pop_cmd && !fifo_empty);

   // A new error in the same cycle as a clear wins, so nothing is lost.
   always_comb begin
      err_d = err_q;
      if (clr_cmd)   err_d = '0;
      if (frame_err) err_d[ERR_FRAME] = 1'b1;
      if (overrun)   err_d[ERR_OVERRUN] = 1'b1;
`ifdef UART_RX_PARITY_EN
      if (parity_err) err_d[ERR_PARITY] = 1'b1;
`else
      err_d[ERR_PARITY] = 1'b0;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ctrl_q  <= 8'h00;
         err_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], RXD};
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ctrl_q  <= RX_CONTROL;
         err_q   <= err_d;
      end
   end

   sync_fifo #(
      .W  (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .push_i  (byte_push),
      .wdata_i (shift_q),
      .pop_i   (pop_cmd),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign RX_STATUS = (fifo_count != '0) ? UART_STAT_READY : UART_STAT_EMPTY;
   assign RX_DATA   = fifo_rdata;
   assign RX_ERR    = {5'b0, err_q};

endmodule
